// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_REL        = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    // A good frame carries an odd number of ones across data plus parity.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_port_receiver_if.sv
// PS/2 pin inputs and decoded key-event outputs between the pins and the matrix mapper.
interface ps2_port_receiver_if;
    logic       clkps2;
    logic       dataps2;
    logic [7:0] code;
    logic       extended;
    logic       released;
    logic       strobe;
    logic       frame_error;

    modport master (
        output clkps2, dataps2,
        input  code, extended, released, strobe, frame_error
    );

    modport slave (
        input  clkps2, dataps2,
        output code, extended, released, strobe, frame_error
    );
endinterface

// File: rtl/ps2_line_filter.sv
// 2-flop synchroniser plus run-length filter for one PS/2 pin; idles high.
// Output follows the pin 2 + FILTER_LEN cycles after a stable change; no backpressure.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_line
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_line;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_line <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            if (r_sync[1] == r_line) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_line <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/ps2_port_receiver.sv
// PS/2 frame deserialiser with E0/F0 prefix folding; strobe/frame_error one cycle after the stop-bit fall.
// No backpressure: the consumer must take every strobe in its cycle.
module ps2_port_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    ps2_port_receiver_if.slave   bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic w_clk_f, w_d, w_fall, w_timeout, w_good, w_bad;
    ps2_state_t r_state, w_state_nxt;

    logic          r_clk_prev;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shreg;
    logic          r_parity;
    logic [TW-1:0] r_tcnt;
    logic          r_pend_ext, r_pend_rel;
    logic [7:0]    r_code;
    logic          r_ext, r_rel, r_strobe, r_ferr;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .reset(reset), .i_pin(bus.clkps2), .o_line(w_clk_f)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk(clk), .reset(reset), .i_pin(bus.dataps2), .o_line(w_d)
    );

    assign w_fall    = r_clk_prev & ~w_clk_f;
    assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                       (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_bad       = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_d) w_state_nxt = ST_DATA;
                    else      w_bad       = 1'b1;
                end
                ST_DATA: begin
                    if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                end
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (w_d && ps2_parity_ok(r_shreg, r_parity)) w_good = 1'b1;
                    else                                          w_bad  = 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_prev <= 1'b1;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
            r_parity   <= 1'b0;
            r_tcnt     <= '0;
            r_pend_ext <= 1'b0;
            r_pend_rel <= 1'b0;
            r_code     <= '0;
            r_ext      <= 1'b0;
            r_rel      <= 1'b0;
            r_strobe   <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_f;
            r_strobe   <= 1'b0;
            r_ferr     <= w_bad;

            if (w_fall || r_state == ST_IDLE) r_tcnt <= '0;
            else                              r_tcnt <= r_tcnt + TW'(1);

            if (w_fall) begin
                case (r_state)
                    ST_IDLE:   r_bitcnt <= '0;
                    ST_DATA: begin
                        r_shreg  <= {w_d, r_shreg[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    ST_PARITY: r_parity <= w_d;
                    default: ;
                endcase
            end

            // Prefix bytes only arm flags; any other good byte publishes and consumes them.
            if (w_bad) begin
                r_pend_ext <= 1'b0;
                r_pend_rel <= 1'b0;
            end else if (w_good) begin
                if (r_shreg == PS2_EXT) begin
                    r_pend_ext <= 1'b1;
                end else if (r_shreg == PS2_REL) begin
                    r_pend_rel <= 1'b1;
                end else begin
                    r_code     <= r_shreg;
                    r_ext      <= r_pend_ext;
                    r_rel      <= r_pend_rel;
                    r_strobe   <= 1'b1;
                    r_pend_ext <= 1'b0;
                    r_pend_rel <= 1'b0;
                end
            end
        end
    end

    assign bus.code        = r_code;
    assign bus.extended    = r_ext;
    assign bus.released    = r_rel;
    assign bus.strobe      = r_strobe;
    assign bus.frame_error = r_ferr;

endmodule

// File: tb/tb_ps2_port_receiver.sv
// Directed bench for ps2_port_receiver: frame table plus latency, timeout, glitch and reset sequences.
module tb_ps2_port_receiver;
    import ps2_pkg::*;

    localparam int FL = 4;
    localparam int TO = 2048;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_port_receiver_if ifc();

    ps2_port_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int checks   = 0;
    int failures = 0;
    int n_strobe = 0;
    int n_ferr   = 0;
    int n_both   = 0;

    always @(negedge clk) begin
        if (ifc.strobe === 1'b1)      n_strobe++;
        if (ifc.frame_error === 1'b1) n_ferr++;
        if (ifc.strobe === 1'b1 && ifc.frame_error === 1'b1) n_both++;
    end

    typedef struct {
        logic [7:0] d;
        logic       par_bad;
        logic       stop;
        int         strobes;
        int         ferrs;
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic d);
        ifc.dataps2 = d;
        wait_cyc(10);
        ifc.clkps2 = 1'b0;
        wait_cyc(20);
        ifc.clkps2 = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop);
        logic [PS2_FRAME_BITS-1:0] f;
        f = {stop, (~^d) ^ par_bad, d, 1'b0};
        for (int i = 0; i < PS2_FRAME_BITS; i++) ps2_bit(f[i]);
        ifc.dataps2 = 1'b1;
        wait_cyc(10);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, e0, lat;
        logic [7:0] b;

        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b1};
        vecs[3]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[4]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[6]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b1, 1'b1};
        vecs[7]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h75, 1'b1, 1'b1};
        vecs[8]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h75, 1'b1, 1'b1};
        vecs[9]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b1, 1'b1};
        vecs[10] = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h75, 1'b1, 1'b1};
        vecs[11] = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h75, 1'b1, 1'b1};
        vecs[12] = '{8'h6B, 1'b0, 1'b1, 1, 0, 8'h6B, 1'b1, 1'b0};
        vecs[13] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h6B, 1'b1, 1'b0};
        vecs[14] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[15] = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[16] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h1C, 1'b0, 1'b0};
        vecs[17] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[18] = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[19] = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'h1C, 1'b0, 1'b0};
        vecs[20] = '{8'h74, 1'b0, 1'b1, 1, 0, 8'h74, 1'b0, 1'b0};

        ifc.clkps2  = 1'b1;
        ifc.dataps2 = 1'b1;
        reset       = 1'b0;
        wait_cyc(3);
        chk("rst code",     32'(ifc.code),        32'h0);
        chk("rst extended", 32'(ifc.extended),    32'h0);
        chk("rst released", 32'(ifc.released),    32'h0);
        chk("rst strobe",   32'(ifc.strobe),      32'h0);
        chk("rst ferr",     32'(ifc.frame_error), 32'h0);
        reset = 1'b1;
        wait_cyc(10);

        for (int i = 0; i < 21; i++) begin
            s0 = n_strobe;
            e0 = n_ferr;
            send_frame(vecs[i].d, vecs[i].par_bad, vecs[i].stop);
            chk($sformatf("v%0d strobes", i),  32'(n_strobe - s0),   32'(vecs[i].strobes));
            chk($sformatf("v%0d ferrs", i),    32'(n_ferr - e0),     32'(vecs[i].ferrs));
            chk($sformatf("v%0d code", i),     32'(ifc.code),        32'(vecs[i].code));
            chk($sformatf("v%0d extended", i), 32'(ifc.extended),    32'(vecs[i].ext));
            chk($sformatf("v%0d released", i), 32'(ifc.released),    32'(vecs[i].rel));
        end

        // Strobe latency: pin fall of the stop bit -> 2 sync + FL filter -> fall cycle -> registered strobe.
        b = 8'h5A;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b);
        ifc.dataps2 = 1'b1;
        wait_cyc(10);
        ifc.clkps2 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            wait_cyc(1);
            if (k == 20) ifc.clkps2 = 1'b1;
            if (ifc.strobe === 1'b1 && lat == 0) lat = k;
        end
        chk("strobe latency", 32'(lat), 32'(FL + 3));
        chk("lat code", 32'(ifc.code), 32'h5A);
        wait_cyc(10);

        // Truncated frame: timeout counter starts after the fall cycle and the pulse is registered.
        s0 = n_strobe;
        e0 = n_ferr;
        b  = 8'h33;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        ifc.dataps2 = b[4];
        wait_cyc(10);
        ifc.clkps2 = 1'b0;
        lat = 0;
        for (int k = 1; k <= TO + 60; k++) begin
            wait_cyc(1);
            if (k == 20) begin
                ifc.clkps2  = 1'b1;
                ifc.dataps2 = 1'b1;
            end
            if (ifc.frame_error === 1'b1 && lat == 0) lat = k;
        end
        chk("timeout latency", 32'(lat), 32'(TO + FL + 3));
        chk("timeout ferrs",   32'(n_ferr - e0),   32'd1);
        chk("timeout strobes", 32'(n_strobe - s0), 32'd0);
        s0 = n_strobe;
        send_frame(8'h29, 1'b0, 1'b1);
        chk("post-timeout strobes",  32'(n_strobe - s0),  32'd1);
        chk("post-timeout code",     32'(ifc.code),       32'h29);
        chk("post-timeout extended", 32'(ifc.extended),   32'h0);
        chk("post-timeout released", 32'(ifc.released),   32'h0);

        // Short clock glitch is filtered; a long low in idle is a real fall with a bad start bit.
        s0 = n_strobe;
        e0 = n_ferr;
        ifc.clkps2 = 1'b0;
        wait_cyc(2);
        ifc.clkps2 = 1'b1;
        wait_cyc(30);
        chk("glitch strobes", 32'(n_strobe - s0), 32'd0);
        chk("glitch ferrs",   32'(n_ferr - e0),   32'd0);
        chk("glitch code",    32'(ifc.code),      32'h29);
        ifc.clkps2 = 1'b0;
        wait_cyc(8);
        ifc.clkps2 = 1'b1;
        wait_cyc(30);
        chk("bad start ferrs",   32'(n_ferr - e0),   32'd1);
        chk("bad start strobes", 32'(n_strobe - s0), 32'd0);

        // Reset mid-frame with an extended prefix pending.
        send_frame(PS2_EXT, 1'b0, 1'b1);
        s0 = n_strobe;
        e0 = n_ferr;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ifc.clkps2 = 1'b0;
        wait_cyc(5);
        reset = 1'b0;
        #1;
        chk("midrst code",     32'(ifc.code),        32'h0);
        chk("midrst extended", 32'(ifc.extended),    32'h0);
        chk("midrst released", 32'(ifc.released),    32'h0);
        chk("midrst strobe",   32'(ifc.strobe),      32'h0);
        chk("midrst ferr",     32'(ifc.frame_error), 32'h0);
        ifc.clkps2  = 1'b1;
        ifc.dataps2 = 1'b1;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(20);
        chk("midrst ferrs", 32'(n_ferr - e0), 32'd0);
        send_frame(8'h29, 1'b0, 1'b1);
        chk("after-rst strobes",  32'(n_strobe - s0), 32'd1);
        chk("after-rst code",     32'(ifc.code),      32'h29);
        chk("after-rst extended", 32'(ifc.extended),  32'h0);
        chk("after-rst released", 32'(ifc.released),  32'h0);

        chk("strobe with frame_error", 32'(n_both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
